buffer_lru_search: RTL and testbench

//  Read-side companion of buffer_lru: looks up a key in the buffer's entry array.

---
 rtl/buffer_lru_search.sv | 127 ++++++++++++
 tb/tb_buffer_lru_search.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/buffer_lru_search.sv
// rtl/buffer_lru_search.sv - key lookup over the buffer_lru entry array, one slot per cycle, with hit/miss counters
module buffer_lru_search #(
    parameter  int WIDTH    = 16,
    parameter  int BUF_SIZE = 8,
    parameter  int CNT_W    = 16,
    localparam int IDX_W    = (BUF_SIZE > 1) ? $clog2(BUF_SIZE) : 1
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [BUF_SIZE*WIDTH-1:0] buf_array_i,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic [WIDTH-1:0]          req_key_i,
    output logic                      resp_valid_o,
    input  logic                      resp_ready_i,
    output logic                      resp_hit_o,
    output logic [IDX_W-1:0]          resp_idx_o,
    input  logic                      clr_cnt_i,
    output logic [CNT_W-1:0]          hit_cnt_o,
    output logic [CNT_W-1:0]          miss_cnt_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_RESP
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [WIDTH-1:0]   r_key;
    logic [IDX_W-1:0]   r_scan_idx;
    logic               r_hit;
    logic [IDX_W-1:0]   r_idx;
    logic [CNT_W-1:0]   r_hit_cnt;
    logic [CNT_W-1:0]   r_miss_cnt;

    logic [WIDTH-1:0]   w_entries [BUF_SIZE];
    logic               w_accept;
    logic               w_resp_hs;
    logic               w_key_zero;
    logic               w_match;
    logic               w_last;

    for (genvar g = 0; g < BUF_SIZE; g++) begin : g_unpack
        assign w_entries[g] = buf_array_i[g*WIDTH +: WIDTH];
    end

    assign req_ready_o  = (r_state == S_IDLE);
    assign resp_valid_o = (r_state == S_RESP);
    assign resp_hit_o   = r_hit;
    assign resp_idx_o   = r_idx;
    assign hit_cnt_o    = r_hit_cnt;
    assign miss_cnt_o   = r_miss_cnt;

    assign w_accept   = req_valid_i && req_ready_o;
    assign w_resp_hs  = resp_valid_o && resp_ready_i;
    // A zero key spends one SCAN cycle and is reported as a miss; empty slots hold 0 and must never hit.
    assign w_key_zero = (r_key == '0);
    assign w_match    = !w_key_zero && (w_entries[r_scan_idx] == r_key);
    assign w_last     = (r_scan_idx == IDX_W'(BUF_SIZE - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next_state = S_SCAN;
            S_SCAN: if (w_key_zero || w_match || w_last) w_next_state = S_RESP;
            S_RESP: if (resp_ready_i) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_key      <= '0;
            r_scan_idx <= '0;
            r_hit      <= 1'b0;
            r_idx      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_key      <= req_key_i;
                        r_scan_idx <= '0;
                    end
                end
                S_SCAN: begin
                    if (w_match) begin
                        r_hit <= 1'b1;
                        r_idx <= r_scan_idx;
                    end else if (w_key_zero || w_last) begin
                        r_hit <= 1'b0;
                        r_idx <= '0;
                    end else begin
                        r_scan_idx <= r_scan_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if (clr_cnt_i) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if (w_resp_hs) begin
            if (r_hit) begin
                if (r_hit_cnt != '1) r_hit_cnt <= r_hit_cnt + 1'b1;
            end else begin
                if (r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_buffer_lru_search.sv
// tb/tb_buffer_lru_search.sv - table-driven directed bench for buffer_lru_search
module tb_buffer_lru_search;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [127:0] buf_array;
    logic         req_valid;
    logic [15:0]  req_key;
    logic         resp_ready;
    logic         clr_cnt;

    logic         req_ready, resp_valid, resp_hit;
    logic [2:0]   resp_idx;
    logic [15:0]  hit_cnt, miss_cnt;

    logic         req_ready2, resp_valid2, resp_hit2;
    logic [2:0]   resp_idx2;
    logic [1:0]   hit_cnt2, miss_cnt2;

    int total = 0;
    int bad   = 0;
    int exp_hit_cnt  = 0;
    int exp_miss_cnt = 0;

    typedef struct {
        logic [15:0] key;
        logic        hit;
        logic [2:0]  idx;
        int          lat;
    } vec_t;
    vec_t vecs [6];

    always #5 clk = ~clk;

    buffer_lru_search #(.WIDTH(16), .BUF_SIZE(8), .CNT_W(16)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .buf_array_i(buf_array),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_key_i(req_key),
        .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
        .resp_hit_o(resp_hit), .resp_idx_o(resp_idx),
        .clr_cnt_i(clr_cnt), .hit_cnt_o(hit_cnt), .miss_cnt_o(miss_cnt)
    );

    buffer_lru_search #(.WIDTH(16), .BUF_SIZE(8), .CNT_W(2)) u_dut2 (
        .clk_i(clk), .rst_ni(rst_n), .buf_array_i(buf_array),
        .req_valid_i(req_valid), .req_ready_o(req_ready2), .req_key_i(req_key),
        .resp_valid_o(resp_valid2), .resp_ready_i(resp_ready),
        .resp_hit_o(resp_hit2), .resp_idx_o(resp_idx2),
        .clr_cnt_i(clr_cnt), .hit_cnt_o(hit_cnt2), .miss_cnt_o(miss_cnt2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic lookup(input logic [15:0] key, input logic exp_hit, input logic [2:0] exp_idx,
                          input int exp_lat, input string tag);
        int lat = 0;
        req_valid = 1'b1;
        req_key   = key;
        step();
        req_valid = 1'b0;
        req_key   = 16'd0;
        while (!resp_valid && lat < 20) begin
            step();
            lat++;
        end
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " hit"}, {31'd0, resp_hit}, {31'd0, exp_hit});
        check({tag, " idx"}, {29'd0, resp_idx}, {29'd0, exp_idx});
    endtask

    task automatic handshake(input logic exp_hit, input logic clr, input string tag);
        resp_ready = 1'b1;
        clr_cnt    = clr;
        step();
        resp_ready = 1'b0;
        clr_cnt    = 1'b0;
        if (clr) begin
            exp_hit_cnt  = 0;
            exp_miss_cnt = 0;
        end else if (exp_hit) begin
            exp_hit_cnt++;
        end else begin
            exp_miss_cnt++;
        end
        check({tag, " hit_cnt"}, {16'd0, hit_cnt}, exp_hit_cnt);
        check({tag, " miss_cnt"}, {16'd0, miss_cnt}, exp_miss_cnt);
        check({tag, " ready after hs"}, {31'd0, req_ready}, 32'd1);
        check({tag, " valid after hs"}, {31'd0, resp_valid}, 32'd0);
    endtask

    initial begin
        vecs[0] = '{key: 16'd103, hit: 1'b1, idx: 3'd3, lat: 4};
        vecs[1] = '{key: 16'd200, hit: 1'b0, idx: 3'd0, lat: 8};
        vecs[2] = '{key: 16'd0,   hit: 1'b0, idx: 3'd0, lat: 1};
        vecs[3] = '{key: 16'd100, hit: 1'b1, idx: 3'd0, lat: 1};
        vecs[4] = '{key: 16'd105, hit: 1'b1, idx: 3'd5, lat: 6};
        vecs[5] = '{key: 16'd107, hit: 1'b1, idx: 3'd7, lat: 8};

        for (int i = 0; i < 8; i++) buf_array[i*16 +: 16] = 16'(100 + i);
        rst_n = 1'b0; req_valid = 1'b0; req_key = 16'd0; resp_ready = 1'b0; clr_cnt = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;

        for (int c = 0; c < 20; c++) begin
            check("idle ready", {31'd0, req_ready}, 32'd1);
            check("idle valid", {31'd0, resp_valid}, 32'd0);
            check("idle counters", {hit_cnt, miss_cnt}, 32'd0);
            step();
        end

        for (int i = 0; i < 6; i++) begin
            lookup(vecs[i].key, vecs[i].hit, vecs[i].idx, vecs[i].lat, $sformatf("vec%0d", i));
            handshake(vecs[i].hit, 1'b0, $sformatf("vec%0d", i));
        end

        lookup(16'd107, 1'b1, 3'd7, 8, "stall");
        for (int c = 0; c < 5; c++) begin
            step();
            check("stall valid", {31'd0, resp_valid}, 32'd1);
            check("stall hit", {31'd0, resp_hit}, 32'd1);
            check("stall idx", {29'd0, resp_idx}, 32'd7);
            check("stall ready", {31'd0, req_ready}, 32'd0);
        end
        handshake(1'b1, 1'b0, "stall");

        req_valid = 1'b1;
        req_key   = 16'd106;
        step();
        req_valid = 1'b0;
        req_key   = 16'd0;
        step();
        step();
        step();
        rst_n = 1'b0;
        #2;
        check("rst valid", {31'd0, resp_valid}, 32'd0);
        check("rst counters", {hit_cnt, miss_cnt}, 32'd0);
        step();
        rst_n = 1'b1;
        exp_hit_cnt  = 0;
        exp_miss_cnt = 0;
        for (int c = 0; c < 8; c++) begin
            step();
            check("post-rst no resp", {31'd0, resp_valid}, 32'd0);
        end
        lookup(16'd101, 1'b1, 3'd1, 2, "after rst");
        handshake(1'b1, 1'b0, "after rst");

        clr_cnt = 1'b1;
        step();
        clr_cnt = 1'b0;
        exp_hit_cnt  = 0;
        exp_miss_cnt = 0;
        check("clr hit_cnt", {16'd0, hit_cnt}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            lookup(16'd100, 1'b1, 3'd0, 1, "sat");
            handshake(1'b1, 1'b0, "sat");
        end
        check("sat narrow hit_cnt", {30'd0, hit_cnt2}, 32'd3);
        check("sat narrow miss_cnt", {30'd0, miss_cnt2}, 32'd0);
        lookup(16'd102, 1'b1, 3'd2, 3, "clr+hs");
        handshake(1'b1, 1'b1, "clr+hs");
        check("clr narrow hit_cnt", {30'd0, hit_cnt2}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
